// File: rtl/dff_pipe_pkg.sv
// Shared constants and helpers for the dff_pipe pipeline.
// Optional feature macro: DFF_PIPE_FLUSH_EN (left undefined by default; no flush port).
package dff_pipe_pkg;

   // Ceiling log2, usable in constant expressions such as port widths.
   function automatic int unsigned clog2_fn(input int unsigned n);
      int unsigned r;
      int unsigned v;
      r = 0;
      v = 1;
      while (v < n) begin
         v = v << 1;
         r = r + 1;
      end
      return r;
   endfunction

   // Occupancy counter width: enough bits to hold 0..depth.
   function automatic int unsigned cnt_width(input int unsigned depth);
      int unsigned w;
      w = clog2_fn(depth + 1);
      return (w == 0) ? 1 : w;
   endfunction

endpackage

// File: rtl/dff_pipe_stage.sv
// One register stage of dff_pipe: valid bit plus data word with ready look-ahead.
// Optional feature macro: DFF_PIPE_FLUSH_EN adds the flush input.
module dff_pipe_stage
   import dff_pipe_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
`ifdef DFF_PIPE_FLUSH_EN
   input  logic             flush,
`endif
   input  logic             up_valid,
   input  logic [WIDTH-1:0] up_data,
   input  logic             dn_ready,
   output logic             v,
   output logic [WIDTH-1:0] d,
   output logic             rdy
);

   logic             v_q;
   logic             v_d;
   logic [WIDTH-1:0] d_q;
   logic [WIDTH-1:0] d_d;
   logic             flush_c;
   logic             load_c;

`ifdef DFF_PIPE_FLUSH_EN
   assign flush_c = flush;
`else
   assign flush_c = 1'b0;
`endif

   // Stage can take a new word when empty or when its word moves on this cycle.
   assign rdy    = !v_q | dn_ready;
   assign load_c = enable & rdy;

   // Next state: flush clears valid only; data loads only with a valid word.
   always_comb begin
      v_d = v_q;
      d_d = d_q;
      if (flush_c) begin
         v_d = 1'b0;
      end else if (load_c) begin
         v_d = up_valid;
         if (up_valid) begin
            d_d = up_data;
         end
      end
   end

   // Stage registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         v_q <= 1'b0;
         d_q <= '0;
      end else begin
         v_q <= v_d;
         d_q <= d_d;
      end
   end

   assign v = v_q;
   assign d = d_q;

endmodule

// File: rtl/dff_pipe.sv
// Parametrised DEPTH-stage valid/ready register pipeline with collapsing bubbles,
// global freeze enable and an occupancy counter.
// Optional feature macro: DFF_PIPE_FLUSH_EN adds a flush input that empties the pipe.
module dff_pipe
   import dff_pipe_pkg::*;
#(
   parameter  int unsigned WIDTH = 8,
   parameter  int unsigned DEPTH = 4,
   localparam int unsigned CW    = cnt_width(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
`ifdef DFF_PIPE_FLUSH_EN
   input  logic             flush,
`endif
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   input  logic             out_ready,
   output logic [CW-1:0]    count
);

   logic [DEPTH-1:0] v_c;
   logic [DEPTH-1:0] rdy_c;
   logic [DEPTH-1:0] up_v_c;
   logic [DEPTH-1:0] dn_rdy_c;
   logic [WIDTH-1:0] d_c    [DEPTH];
   logic [WIDTH-1:0] up_d_c [DEPTH];
   logic             flush_c;
   logic             in_xfer_c;
   logic             out_xfer_c;
   logic [CW-1:0]    count_q;
   logic [CW-1:0]    count_d;

`ifdef DFF_PIPE_FLUSH_EN
   assign flush_c = flush;
`else
   assign flush_c = 1'b0;
`endif

   // Stage chain: valid/data flow toward DEPTH-1, ready flows back toward 0.
   for (genvar i = 0; i < DEPTH; i++) begin : g_stage
      if (i == 0) begin : g_first
         assign up_v_c[i] = in_valid;
         assign up_d_c[i] = in_data;
      end else begin : g_mid
         assign up_v_c[i] = v_c[i-1];
         assign up_d_c[i] = d_c[i-1];
      end

      if (i == DEPTH - 1) begin : g_last
         assign dn_rdy_c[i] = out_ready;
      end else begin : g_inner
         assign dn_rdy_c[i] = rdy_c[i+1];
      end

      dff_pipe_stage #(
         .WIDTH (WIDTH)
      ) u_stage (
         .clk      (clk),
         .reset    (reset),
         .enable   (enable),
`ifdef DFF_PIPE_FLUSH_EN
         .flush    (flush),
`endif
         .up_valid (up_v_c[i]),
         .up_data  (up_d_c[i]),
         .dn_ready (dn_rdy_c[i]),
         .v        (v_c[i]),
         .d        (d_c[i]),
         .rdy      (rdy_c[i])
      );
   end

   // Handshake outputs; freeze and flush both block transfers.
   assign in_ready   = enable & rdy_c[0] & !flush_c;
   assign out_valid  = enable & v_c[DEPTH-1] & !flush_c;
   assign out_data   = d_c[DEPTH-1];
   assign in_xfer_c  = in_valid & in_ready;
   assign out_xfer_c = out_valid & out_ready;

   // Occupancy next value: net of accepted and delivered words.
   always_comb begin
      count_d = count_q;
      if (flush_c) begin
         count_d = '0;
      end else begin
         count_d = count_q + CW'(in_xfer_c) - CW'(out_xfer_c);
      end
   end

   // Occupancy register with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: tb/tb_dff_pipe.sv
// Self-checking bench for dff_pipe: directed scenarios plus randomized traffic,
// compared against a word-position reference model.
module tb_dff_pipe;

   localparam int WIDTH = 8;
   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH + 1);

   logic             clk;
   logic             reset;
   logic             enable;
   logic             flush_s;
   logic             in_valid;
   logic [WIDTH-1:0] in_data;
   logic             in_ready;
   logic             out_valid;
   logic [WIDTH-1:0] out_data;
   logic             out_ready;
   logic [CW-1:0]    count;

   dff_pipe #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .enable    (enable),
`ifdef DFF_PIPE_FLUSH_EN
      .flush     (flush_s),
`endif
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready),
      .count     (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: words in flight, oldest first, each with its stage position.
   int               mpos[$];
   logic [WIDTH-1:0] mdat[$];
   logic [WIDTH-1:0] last_d;
   bit               acc;
   int               n_out;
   int               cyc;
   int               cur;
   bit               chk_on;

   logic             obs_ir;
   logic             obs_ov;
   logic [WIDTH-1:0] obs_od;
   logic [CW-1:0]    obs_cnt;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance the model by one clock edge with the given inputs.
   task automatic model_step(input bit rst, input bit en, input bit fl, input bit iv,
                             input logic [WIDTH-1:0] id, input bit ordy);
      int lim;
      int np;
      acc = 1'b0;
      if (rst) begin
         mpos.delete();
         mdat.delete();
         last_d = '0;
      end else if (fl) begin
         mpos.delete();
         mdat.delete();
      end else if (en) begin
         acc = iv && ((mpos.size() < DEPTH) || ordy);
         if (mpos.size() > 0 && mpos[0] == DEPTH - 1 && ordy) begin
            void'(mpos.pop_front());
            void'(mdat.pop_front());
            n_out++;
         end
         lim = DEPTH - 1;
         for (int k = 0; k < mpos.size(); k++) begin
            np = (mpos[k] + 1 > lim) ? lim : mpos[k] + 1;
            if (np != mpos[k] && np == DEPTH - 1) last_d = mdat[k];
            mpos[k] = np;
            lim = np - 1;
         end
         if (acc) begin
            mpos.push_back(0);
            mdat.push_back(id);
            if (DEPTH == 1) last_d = id;
         end
      end
   endtask

   // One clock cycle: drive, check outputs against the model, clock, update model.
   task automatic cycle(input bit rst, input bit en, input bit fl, input bit iv,
                        input logic [WIDTH-1:0] id, input bit ordy);
      bit e_ir;
      bit e_ov;
      reset     = rst;
      enable    = en;
      flush_s   = fl;
      in_valid  = iv;
      in_data   = id;
      out_ready = ordy;
      #1;
      obs_ir  = in_ready;
      obs_ov  = out_valid;
      obs_od  = out_data;
      obs_cnt = count;
      cur     = cyc;
      if (chk_on) begin
         e_ir = en && !fl && ((mpos.size() < DEPTH) || ordy);
         e_ov = en && !fl && (mpos.size() > 0) && (mpos[0] == DEPTH - 1);
         chk("in_ready", 32'(obs_ir), 32'(e_ir));
         chk("out_valid", 32'(obs_ov), 32'(e_ov));
         chk("out_data", 32'(obs_od), 32'(last_d));
         chk("count", 32'(obs_cnt), 32'(mpos.size()));
      end
      @(posedge clk);
      model_step(rst, en, fl, iv, id, ordy);
      cyc++;
      @(negedge clk);
   endtask

   initial begin
      int               t_acc;
      int               t_ov;
      int               nsent;
      logic [WIDTH-1:0] seen[$];
      logic [WIDTH-1:0] w;

      n_out   = 0;
      cyc     = 0;
      chk_on  = 1'b0;
      last_d  = '0;
      flush_s = 1'b0;

      // Reset for two cycles with valid input offered.
      cycle(1, 1, 0, 1, 8'hAA, 0);
      chk_on = 1'b1;
      cycle(1, 1, 0, 1, 8'hAA, 0);
      cycle(0, 1, 0, 0, 8'h00, 0);
      chk("rst_out_valid", 32'(obs_ov), 32'd0);
      chk("rst_count", 32'(obs_cnt), 32'd0);
      chk("rst_out_data", 32'(obs_od), 32'd0);
      chk("rst_in_ready", 32'(obs_ir), 32'd1);

      // Streaming 01..08 back-to-back with out_ready held high.
      t_acc = -1;
      t_ov  = -1;
      nsent = 0;
      n_out = 0;
      for (int i = 0; i < 20; i++) begin
         cycle(0, 1, 0, nsent < 8, WIDTH'(nsent + 1), 1);
         if (t_ov < 0 && obs_ov) t_ov = cur;
         if (acc && t_acc < 0) t_acc = cur;
         if (acc) nsent++;
      end
      chk("stream_latency", 32'(t_ov - t_acc), 32'(DEPTH));
      chk("stream_outs", 32'(n_out), 32'd8);

      // Backpressure: bubbles collapse while out_ready is low.
      cycle(0, 1, 0, 1, 8'h01, 0);
      cycle(0, 1, 0, 0, 8'h00, 0);
      cycle(0, 1, 0, 0, 8'h00, 0);
      cycle(0, 1, 0, 1, 8'h02, 0);
      cycle(0, 1, 0, 0, 8'h00, 0);
      chk("bp_count2", 32'(obs_cnt), 32'd2);
      cycle(0, 1, 0, 1, 8'h03, 0);
      cycle(0, 1, 0, 1, 8'h04, 0);
      cycle(0, 1, 0, 0, 8'h00, 0);
      chk("bp_count4", 32'(obs_cnt), 32'd4);
      chk("bp_in_ready_full", 32'(obs_ir), 32'd0);
      seen.delete();
      for (int i = 0; i < 6; i++) begin
         cycle(0, 1, 0, 0, 8'h00, 1);
         if (obs_ov) seen.push_back(obs_od);
      end
      chk("bp_drain_n", 32'(seen.size()), 32'd4);
      for (int i = 0; i < seen.size(); i++) begin
         w = seen[i];
         chk("bp_order", 32'(w), 32'(i + 1));
      end

      // Full pipeline with simultaneous in/out transfer.
      for (int i = 0; i < 10 && mpos.size() < DEPTH; i++) begin
         cycle(0, 1, 0, 1, WIDTH'($urandom), 0);
      end
      for (int i = 0; i < 5; i++) begin
         cycle(0, 1, 0, 1, WIDTH'($urandom), 1);
         chk("full_count", 32'(obs_cnt), 32'(DEPTH));
      end

      // Freeze mid-stream for three cycles.
      for (int i = 0; i < 3; i++) begin
         cycle(0, 0, 0, 1, WIDTH'($urandom), 1);
         chk("freeze_in_ready", 32'(obs_ir), 32'd0);
         chk("freeze_out_valid", 32'(obs_ov), 32'd0);
      end
      for (int i = 0; i < 8; i++) begin
         cycle(0, 1, 0, i < 3, WIDTH'($urandom), 1);
      end

`ifdef DFF_PIPE_FLUSH_EN
      // Flush with three words in flight, then one fresh word.
      cycle(1, 1, 0, 0, 8'h00, 0);
      cycle(0, 1, 0, 1, 8'h11, 0);
      cycle(0, 1, 0, 1, 8'h22, 0);
      cycle(0, 1, 0, 1, 8'h33, 0);
      cycle(0, 1, 0, 0, 8'h00, 0);
      chk("flush_pre_count", 32'(obs_cnt), 32'd3);
      cycle(0, 1, 1, 1, 8'h77, 1);
      cycle(0, 1, 0, 0, 8'h00, 1);
      chk("flush_count", 32'(obs_cnt), 32'd0);
      chk("flush_out_valid", 32'(obs_ov), 32'd0);
      t_acc = -1;
      t_ov  = -1;
      for (int i = 0; i < 8; i++) begin
         cycle(0, 1, 0, i == 0, 8'h55, 1);
         if (acc && t_acc < 0) t_acc = cur;
         if (obs_ov && t_ov < 0) begin
            t_ov = cur;
            chk("flush_word", 32'(obs_od), 32'h55);
         end
      end
      chk("flush_latency", 32'(t_ov - t_acc), 32'(DEPTH));
`endif

      // Randomized traffic with occasional freeze, reset and flush.
      for (int i = 0; i < 400; i++) begin
         bit rb;
         bit fb;
         rb = ($urandom_range(0, 99) == 0);
`ifdef DFF_PIPE_FLUSH_EN
         fb = ($urandom_range(0, 39) == 0);
`else
         fb = 1'b0;
`endif
         cycle(rb, $urandom_range(0, 9) != 0, fb, 1'($urandom),
               WIDTH'($urandom), 1'($urandom));
      end
      for (int i = 0; i < 2 * DEPTH; i++) begin
         cycle(0, 1, 0, 0, 8'h00, 1);
      end
      chk("final_empty", 32'(obs_cnt), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
